key_pulse_gen: RTL
==================

// Module: key_pulse_gen
// PURPOSE
//   Front end for the signal-generator key path: synchronises and debounces the four
//   raw active-low push-buttons into the active-low, one-cycle key events that the
//   key/parameter control logic consumes (one low cycle = one step).
//   Adds optional auto-repeat so a held increment key steps freq/phase/amp repeatedly.
//   Sits between the board pins and the key control block in the 50 MHz domain.
// PARAMETERS
//   N_KEYS          4           number of keys
//   CLK_FREQ_HZ     50_000_000  clk_50m frequency
//   DEBOUNCE_MS     20          stable time required to accept a press or release
//   REPEAT_DELAY_MS 500         hold time from first pulse to first repeat pulse
//   REPEAT_RATE_MS  100         period of subsequent repeat pulses
//   REPEAT_EN       4'b0100     per-key auto-repeat enable (default: key[2] only)
// PORTS
//   clk_50m    in   1       system clock
//   rst_n      in   1       synchronous active-low reset
//   key_raw    in   N_KEYS  raw buttons, active-low, asynchronous, bouncing
//   key_pulse  out  N_KEYS  active-low event, exactly one clk_50m cycle per accepted press/repeat
//   key_level  out  N_KEYS  debounced level, active-low (0 = pressed)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low: on a clk_50m edge with rst_n=0, all
//     state is cleared. The synchroniser loads 1s, key_pulse=all 1s, key_level=all 1s,
//     every key FSM goes to IDLE, and all counters load 0.
//   - Derived constants (integer): DB = CLK_FREQ_HZ/1000*DEBOUNCE_MS, RD = ..*REPEAT_DELAY_MS,
//     RR = ..*REPEAT_RATE_MS. Counter widths are $clog2(max+1); no counter may wrap.
//   - Per key: 2-flop synchroniser -> key_sync. Key_raw is sampled at edge E; key_sync
//     is valid after E+1.
//   - Debounce: cnt increments on each edge where key_sync != key_level. Cnt clears on
//     any edge where they are equal. On the edge where cnt == DB-1 and they still differ,
//     key_level flips and cnt clears. A clean press sampled at edge E therefore gives
//     key_level=0 after edge E+DB+1.
//   - FSM per key, independent of other keys: IDLE -> HELD -> (REPEAT) -> IDLE.
//     IDLE: on the accepted press (key_level 1->0 edge), drive key_pulse=0 for that one
//       cycle, load rep_cnt=0, and go to HELD.
//     HELD: if REPEAT_EN[i]=0, stay until release. Otherwise rep_cnt++; at rep_cnt==RD-1,
//       pulse, clear rep_cnt, and go to REPEAT.
//     REPEAT: rep_cnt++; at rep_cnt==RR-1, pulse and clear rep_cnt.
//     HELD/REPEAT: an accepted release (key_level 0->1) returns the FSM to IDLE with no
//       pulse. If a repeat pulse would fall on that same edge, the release wins and no
//       pulse is issued.
//   - Glitches shorter than DB cycles never change key_level, never pulse, and do not
//     reset rep_cnt.
//   - key_pulse is registered and returns to 1 on the next edge. Back-to-back pulses are
//     impossible because RR >= 1 ms.
//   - Keys held through reset: after rst_n rises, treat as a new press. Need DB stable
//     cycles, then exactly one pulse. No pulse is issued during reset.
//   - Simultaneous events on several keys pulse in the same cycle. Key priority belongs
//     to the consumer.
// TESTING (bench overrides CLK_FREQ_HZ=10_000 -> DB=200, RD=5000, RR=1000)
//   1 key_raw[0] 1->0 sampled at edge E, held 1000 cyc -> one key_pulse[0]=0 cycle after
//     E+201, key_level[0]=0 from E+201, no further pulses; release -> level 1 after 201, no pulse.
//   2 key_raw[1] toggles every 50 cyc for 600 cyc, then stays low -> no pulse during bounce;
//     single pulse 201 cyc after the last toggle is sampled.
//   3 key_raw[2] held 8000 cyc -> pulses at P, P+5000, P+6000, P+7000 (P = first pulse);
//     key_raw[0] held 8000 cyc -> only pulse P.
//   4 key_raw[3] low glitch 150 cyc, also a 150 cyc high glitch mid-hold on key[2] ->
//     no extra pulse, key_level unchanged, repeat timing unchanged.
//   5 rst_n=0 for 10 cyc while key[2] held in REPEAT -> outputs all 1 during reset;
//     after release, one pulse at reset-release+202, repeats resume after RD.
//   6 key_raw[0] and key_raw[1] fall on the same edge -> key_pulse[0] and key_pulse[1]
//     low in the same cycle.

Source files
------------

// File: rtl/key_pulse_gen_if.sv
// Key path bundle between the board buttons and the key control logic.
//   key_raw   : raw active-low buttons (asynchronous, bouncing)
//   key_pulse : active-low one-cycle key events
//   key_level : debounced active-low key levels
// master = pin/stimulus side, slave = key_pulse_gen.
interface key_pulse_gen_if #(
  parameter int unsigned N_KEYS = 4
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_pulse;
  logic [N_KEYS-1:0] key_level;

  modport master (output key_raw, input key_pulse, input key_level);
  modport slave  (input key_raw, output key_pulse, output key_level);
endinterface

// File: rtl/key_pulse_gen.sv
// Synchronises, debounces and auto-repeats the raw push-buttons into
// active-low single-cycle key events for the key/parameter control block.
// Ports:
//   clk_50m : system clock
//   rst_n   : synchronous active-low reset
//   kif     : key_pulse_gen_if.slave (key_raw in; key_pulse, key_level out)
// The interface N_KEYS must match this module's N_KEYS.
module key_pulse_gen #(
  parameter int unsigned       N_KEYS          = 4,
  parameter int unsigned       CLK_FREQ_HZ     = 50_000_000,
  parameter int unsigned       DEBOUNCE_MS     = 20,
  parameter int unsigned       REPEAT_DELAY_MS = 500,
  parameter int unsigned       REPEAT_RATE_MS  = 100,
  parameter logic [N_KEYS-1:0] REPEAT_EN       = N_KEYS'(4'b0100)
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  key_pulse_gen_if.slave   kif
);

  localparam int unsigned CYC_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int unsigned DB         = CYC_PER_MS * DEBOUNCE_MS;
  localparam int unsigned RD         = CYC_PER_MS * REPEAT_DELAY_MS;
  localparam int unsigned RR         = CYC_PER_MS * REPEAT_RATE_MS;
  localparam int unsigned REP_MAX    = (RD > RR) ? RD : RR;
  localparam int unsigned DB_W       = $clog2(DB + 1);
  localparam int unsigned REP_W      = $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_REPEAT
  } state_e;

  logic [N_KEYS-1:0] meta_q, meta_d;
  logic [N_KEYS-1:0] sync_q, sync_d;
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] pulse_q, pulse_d;
  logic [DB_W-1:0]   db_cnt_q  [N_KEYS];
  logic [DB_W-1:0]   db_cnt_d  [N_KEYS];
  logic [REP_W-1:0]  rep_cnt_q [N_KEYS];
  logic [REP_W-1:0]  rep_cnt_d [N_KEYS];
  state_e            state_q   [N_KEYS];
  state_e            state_d   [N_KEYS];
  logic [N_KEYS-1:0] press_c;
  logic [N_KEYS-1:0] release_c;

  // State registers; reset loads the "released" view of every key.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      meta_q  <= '1;
      sync_q  <= '1;
      level_q <= '1;
      pulse_q <= '1;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        db_cnt_q[i]  <= '0;
        rep_cnt_q[i] <= '0;
        state_q[i]   <= ST_IDLE;
      end
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
        state_q[i]   <= state_d[i];
      end
    end
  end

  // Synchroniser, debounce and per-key press/repeat FSM next-state logic.
  always_comb begin
    meta_d    = kif.key_raw;
    sync_d    = meta_q;
    level_d   = level_q;
    pulse_d   = '1;
    press_c   = '0;
    release_c = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      db_cnt_d[i]  = '0;
      rep_cnt_d[i] = rep_cnt_q[i];
      state_d[i]   = state_q[i];

      // Level flips only after DB consecutive disagreeing samples.
      if (sync_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB - 1)) begin
          level_d[i]   = sync_q[i];
          press_c[i]   = ~sync_q[i];
          release_c[i] = sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end

      // rep_cnt keeps counting through glitches; only a release stops it.
      unique case (state_q[i])
        ST_IDLE: begin
          if (press_c[i]) begin
            pulse_d[i]   = 1'b0;
            rep_cnt_d[i] = '0;
            state_d[i]   = ST_HELD;
          end
        end
        ST_HELD: begin
          if (release_c[i]) begin
            state_d[i] = ST_IDLE;
          end else if (REPEAT_EN[i]) begin
            if (rep_cnt_q[i] == REP_W'(RD - 1)) begin
              pulse_d[i]   = 1'b0;
              rep_cnt_d[i] = '0;
              state_d[i]   = ST_REPEAT;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
            end
          end
        end
        ST_REPEAT: begin
          if (release_c[i]) begin
            state_d[i] = ST_IDLE;
          end else if (rep_cnt_q[i] == REP_W'(RR - 1)) begin
            pulse_d[i]   = 1'b0;
            rep_cnt_d[i] = '0;
          end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  assign kif.key_pulse = pulse_q;
  assign kif.key_level = level_q;

endmodule
